// File: rtl/lcd_write_arbiter_if.sv
// One requester's write channel into lcd_write_arbiter.
// The requester holds req/data/cd stable until ack pulses.
interface lcd_write_arbiter_if;
  localparam int unsigned DATA_W = 32;

  logic              req;
  logic [DATA_W-1:0] data;
  logic              cd;
  logic              ack;

  modport master (output req, output data, output cd, input ack);
  modport slave  (input req, input data, input cd, output ack);
endinterface

// File: rtl/lcd_write_arbiter.sv
// Round-robin arbiter sharing one LCD write port between two requesters.
// Optional LCD_ARB_TIMEOUT_EN adds a WAIT-state timeout that force-releases and pulses err.
module lcd_write_arbiter #(
  parameter int unsigned GUARD_CYCLES   = 2
`ifdef LCD_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic                clk,
  input  logic                rst,
  lcd_write_arbiter_if.slave  rq0,
  lcd_write_arbiter_if.slave  rq1,
  output logic [31:0]         lcd_data,
  output logic                lcd_cd,
  output logic                lcd_en,
  input  logic                lcd_available,
  output logic [1:0]          grant,
  output logic                busy,
  output logic                err
);

  localparam int unsigned GUARD_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
`ifdef LCD_ARB_TIMEOUT_EN
  localparam int unsigned TIMEOUT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_GUARD = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  logic [1:0]         state, state_nxt;
  logic [GUARD_W-1:0] gcnt, gcnt_nxt;
  logic               ptr, ptr_nxt;
  logic [31:0]        data_nxt;
  logic               cd_nxt, en_nxt, busy_nxt, err_nxt;
  logic [1:0]         grant_nxt;
  logic               ack0_q, ack1_q, ack0_nxt, ack1_nxt;
  logic               win_c;
`ifdef LCD_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tcnt, tcnt_nxt;
`endif

  // ptr=0 gives requester 0 the tie; a sole requester always wins
  assign win_c   = (rq0.req && rq1.req) ? ptr : rq1.req;
  assign rq0.ack = ack0_q;
  assign rq1.ack = ack1_q;

  always_comb begin
    state_nxt = state;
    gcnt_nxt  = gcnt;
    ptr_nxt   = ptr;
    data_nxt  = lcd_data;
    cd_nxt    = lcd_cd;
    en_nxt    = 1'b0;
    grant_nxt = grant;
    busy_nxt  = busy;
    ack0_nxt  = 1'b0;
    ack1_nxt  = 1'b0;
    err_nxt   = 1'b0;
`ifdef LCD_ARB_TIMEOUT_EN
    tcnt_nxt  = tcnt;
`endif
    case (state)
      S_IDLE: begin
        if (lcd_available && (rq0.req || rq1.req)) begin
          data_nxt  = win_c ? rq1.data : rq0.data;
          cd_nxt    = win_c ? rq1.cd : rq0.cd;
          grant_nxt = win_c ? 2'b10 : 2'b01;
          en_nxt    = 1'b1;
          busy_nxt  = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        gcnt_nxt  = GUARD_W'(GUARD_CYCLES - 1);
        state_nxt = S_GUARD;
      end
      S_GUARD: begin
        // lcd_available may still show the pre-write level here
        if (gcnt == '0) begin
          state_nxt = S_WAIT;
`ifdef LCD_ARB_TIMEOUT_EN
          tcnt_nxt  = '0;
`endif
        end else begin
          gcnt_nxt = gcnt - GUARD_W'(1);
        end
      end
      S_WAIT: begin
        if (lcd_available) begin
          ack0_nxt  = grant[0];
          ack1_nxt  = grant[1];
          ptr_nxt   = grant[0];
          grant_nxt = 2'b00;
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end
`ifdef LCD_ARB_TIMEOUT_EN
        else if (tcnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
          ack0_nxt  = grant[0];
          ack1_nxt  = grant[1];
          ptr_nxt   = grant[0];
          grant_nxt = 2'b00;
          busy_nxt  = 1'b0;
          err_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          tcnt_nxt = tcnt + TIMEOUT_W'(1);
        end
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      gcnt     <= '0;
      ptr      <= 1'b0;
      lcd_data <= '0;
      lcd_cd   <= 1'b0;
      lcd_en   <= 1'b0;
      grant    <= 2'b00;
      busy     <= 1'b0;
      err      <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
`ifdef LCD_ARB_TIMEOUT_EN
      tcnt     <= '0;
`endif
    end else begin
      state    <= state_nxt;
      gcnt     <= gcnt_nxt;
      ptr      <= ptr_nxt;
      lcd_data <= data_nxt;
      lcd_cd   <= cd_nxt;
      lcd_en   <= en_nxt;
      grant    <= grant_nxt;
      busy     <= busy_nxt;
      err      <= err_nxt;
      ack0_q   <= ack0_nxt;
      ack1_q   <= ack1_nxt;
`ifdef LCD_ARB_TIMEOUT_EN
      tcnt     <= tcnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Directed bench for lcd_write_arbiter with a simple busy-for-N-cycles LCD model.
module tb_lcd_write_arbiter;
  logic        clk;
  logic        rst;
  logic [31:0] lcd_data;
  logic        lcd_cd, lcd_en, lcd_available, busy, err;
  logic [1:0]  grant;

  int n_checks = 0;
  int n_errs   = 0;

  lcd_write_arbiter_if rq0_if ();
  lcd_write_arbiter_if rq1_if ();

  lcd_write_arbiter #(
    .GUARD_CYCLES(2)
`ifdef LCD_ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk(clk), .rst(rst), .rq0(rq0_if), .rq1(rq1_if),
    .lcd_data(lcd_data), .lcd_cd(lcd_cd), .lcd_en(lcd_en),
    .lcd_available(lcd_available), .grant(grant), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // LCD model: goes busy for busy_len cycles after each write strobe
  int   busy_len = 3;
  int   busy_cnt = 0;
  logic hold_low = 1'b0;
  logic glitch   = 1'b0;
  always @(posedge clk or negedge rst) begin
    if (!rst) busy_cnt <= 0;
    else if (lcd_en) busy_cnt <= busy_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign lcd_available = ((busy_cnt == 0) && !hold_low) || glitch;

  int en_pulses = 0, err_pulses = 0, ack0_cnt = 0, ack1_cnt = 0;
  always @(negedge clk) begin
    if (lcd_en) en_pulses <= en_pulses + 1;
    if (err) err_pulses <= err_pulses + 1;
    if (rq0_if.ack) ack0_cnt <= ack0_cnt + 1;
    if (rq1_if.ack) ack1_cnt <= ack1_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_en(output int cyc, output logic ok);
    ok = 1'b0; cyc = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (lcd_en) begin ok = 1'b1; cyc = i; return; end
    end
  endtask

  task automatic wait_ack(output int cyc, output logic [1:0] acks);
    acks = 2'b00; cyc = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (rq0_if.ack || rq1_if.ack) begin acks = {rq1_if.ack, rq0_if.ack}; cyc = i; return; end
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  int         cyc, cyc2, snap;
  logic       ok;
  logic [1:0] acks;
  logic [1:0] exp_g;

  initial begin
    rst = 1'b0;
    rq0_if.req = 1'b0; rq0_if.data = '0; rq0_if.cd = 1'b0;
    rq1_if.req = 1'b0; rq1_if.data = '0; rq1_if.cd = 1'b0;
    cycles(3);
    check_eq("rst_en", 32'(lcd_en), 0);
    check_eq("rst_grant", 32'(grant), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_data", lcd_data, 0);
    rst = 1'b1;
    cycles(2);

    // single write from requester 0, LCD busy 20 cycles
    busy_len = 20;
    snap = en_pulses;
    rq0_if.req = 1'b1; rq0_if.data = 32'h48454C4C; rq0_if.cd = 1'b1;
    wait_en(cyc, ok);
    check_eq("t2_en_seen", 32'(ok), 1);
    check_eq("t2_en_lat", cyc, 1);
    check_eq("t2_grant", 32'(grant), 32'b01);
    check_eq("t2_data", lcd_data, 32'h48454C4C);
    check_eq("t2_cd", 32'(lcd_cd), 1);
    wait_ack(cyc, acks);
    rq0_if.req = 1'b0;
    check_eq("t2_ack", 32'(acks), 32'b01);
    check_eq("t2_ack_lat", cyc, 22);
    check_eq("t2_grant_rel", 32'(grant), 0);
    check_eq("t2_busy_rel", 32'(busy), 0);
    cycles(1);
    check_eq("t2_ack_pulse", 32'(rq0_if.ack), 0);
    check_eq("t2_en_count", en_pulses - snap, 1);
    check_eq("t2_data_hold", lcd_data, 32'h48454C4C);

    // async reset mid-transfer: outputs clear without a clock edge, no ack
    snap = ack1_cnt;
    rq1_if.req = 1'b1; rq1_if.data = 32'h11223344; rq1_if.cd = 1'b1;
    wait_en(cyc, ok);
    check_eq("t1_en_seen", 32'(ok), 1);
    #2 rst = 1'b0;
    #1;
    check_eq("t1_en", 32'(lcd_en), 0);
    check_eq("t1_grant", 32'(grant), 0);
    check_eq("t1_busy", 32'(busy), 0);
    check_eq("t1_data", lcd_data, 0);
    check_eq("t1_cd", 32'(lcd_cd), 0);
    rq1_if.req = 1'b0;
    cycles(2);
    rst = 1'b1;
    cycles(4);
    check_eq("t1_no_ack", ack1_cnt - snap, 0);

    // both requesters continuous: strict alternation starting with 0
    busy_len = 2;
    rq0_if.req = 1'b1; rq0_if.data = 32'h43505530; rq0_if.cd = 1'b1;
    rq1_if.req = 1'b1; rq1_if.data = 32'h44424731; rq1_if.cd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 1) ? 2'b10 : 2'b01;
      wait_en(cyc, ok);
      check_eq($sformatf("t3_en%0d", i), 32'(ok), 1);
      check_eq($sformatf("t3_grant%0d", i), 32'(grant), 32'(exp_g));
      check_eq($sformatf("t3_data%0d", i), lcd_data, exp_g[1] ? 32'h44424731 : 32'h43505530);
      wait_ack(cyc, acks);
      check_eq($sformatf("t3_ack%0d", i), 32'(acks), 32'(exp_g));
    end
    rq0_if.req = 1'b0; rq1_if.req = 1'b0;
    cycles(3);

    // LCD unavailable at request; glitch high through GUARD ignored
    hold_low = 1'b1;
    snap = en_pulses;
    rq0_if.req = 1'b1; rq0_if.data = 32'h0A0B0C0D; rq0_if.cd = 1'b0;
    cycles(5);
    check_eq("t4_no_en", en_pulses - snap, 0);
    check_eq("t4_no_grant", 32'(grant), 0);
    busy_len = 40;
    hold_low = 1'b0;
    wait_en(cyc, ok);
    check_eq("t4_en_after", 32'(ok), 1);
    check_eq("t4_en_lat", cyc, 1);
    glitch = 1'b1;
    cycles(1);
    check_eq("t4_guard_ack_a", 32'(rq0_if.ack), 0);
    cycles(1);
    check_eq("t4_guard_ack_b", 32'(rq0_if.ack), 0);
    cycles(1);
    check_eq("t4_guard_busy", 32'(busy), 1);
    glitch = 1'b0;
    wait_ack(cyc, acks);
    rq0_if.req = 1'b0;
    check_eq("t4_ack", 32'(acks), 32'b01);
    check_eq("t4_ack_lat", cyc + 3, 42);
    cycles(2);

    // requester 1 drops req and changes data after grant
    busy_len = 5;
    rq1_if.req = 1'b1; rq1_if.data = 32'h41424344; rq1_if.cd = 1'b0;
    wait_en(cyc, ok);
    check_eq("t5_en", 32'(ok), 1);
    check_eq("t5_grant", 32'(grant), 32'b10);
    rq1_if.req = 1'b0; rq1_if.data = 32'hDEADBEEF; rq1_if.cd = 1'b1;
    cycles(2);
    check_eq("t5_data_mid", lcd_data, 32'h41424344);
    check_eq("t5_cd_mid", 32'(lcd_cd), 0);
    wait_ack(cyc, acks);
    check_eq("t5_ack", 32'(acks), 32'b10);
    snap = en_pulses;
    cycles(3);
    check_eq("t5_data_hold", lcd_data, 32'h41424344);
    check_eq("t5_no_regrant", en_pulses - snap, 0);
    check_eq("t5_grant_idle", 32'(grant), 0);

    // LCD stuck busy after the strobe
    busy_len = 200;
    snap = ack0_cnt;
    rq0_if.req = 1'b1; rq0_if.data = 32'h5A5A5A5A; rq0_if.cd = 1'b1;
    wait_en(cyc, ok);
    check_eq("t6_en", 32'(ok), 1);
`ifdef LCD_ARB_TIMEOUT_EN
    wait_ack(cyc, acks);
    rq0_if.req = 1'b0;
    check_eq("t6_to_ack", 32'(acks), 32'b01);
    check_eq("t6_to_lat", cyc, 19);
    check_eq("t6_to_err", 32'(err), 1);
    check_eq("t6_to_busy", 32'(busy), 0);
    cycles(1);
    check_eq("t6_err_pulse", 32'(err), 0);
`else
    cycles(40);
    check_eq("t6_busy_held", 32'(busy), 1);
    check_eq("t6_no_ack", ack0_cnt - snap, 0);
    check_eq("t6_err_zero", err_pulses, 0);
    wait_ack(cyc2, acks);
    rq0_if.req = 1'b0;
    check_eq("t6_late_ack", 32'(acks), 32'b01);
    check_eq("t6_late_lat", cyc2 + 40, 202);
    cycles(1);
    check_eq("t6_err_total", err_pulses, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
